// File: rtl/lcd_cmd_pacer_if.sv
// Command/strobe bundle between a register-write producer, the pacer and the
// LCD driver stage. The master side offers commands; the slave side is the pacer.
interface lcd_cmd_pacer_if #(
  parameter int DEPTH = 8
);
  localparam int LVL_W = $clog2(DEPTH) + 1;

  logic             in_valid;
  logic             in_rs;
  logic [7:0]       in_data;
  logic             in_ready;
  logic             out_wenable;
  logic             out_rs;
  logic [7:0]       out_wdata;
  logic             busy;
  logic [LVL_W-1:0] level;
  logic             drop;

  modport master (
    output in_valid, in_rs, in_data,
    input  in_ready, out_wenable, out_rs, out_wdata, busy, level, drop
  );

  modport slave (
    input  in_valid, in_rs, in_data,
    output in_ready, out_wenable, out_rs, out_wdata, busy, level, drop
  );
endinterface

// File: rtl/lcd_cmd_pacer.sv
// LCD command pacer: buffers register-select/byte pairs in a small FIFO and
// issues them one at a time, leaving the controller's execution time between
// strobes (a long wait after clear/home, a short wait otherwise).
module lcd_cmd_pacer #(
  parameter int DEPTH      = 8,
  parameter int SHORT_WAIT = 2000,
  parameter int LONG_WAIT  = 80000,
  parameter int CNT_W      = 17
) (
  input  logic              clk,
  input  logic              rst,
  lcd_cmd_pacer_if.slave    bus
);
  localparam int AW    = $clog2(DEPTH);
  localparam int LVL_W = AW + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t           state_q;
  logic [8:0]       mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [LVL_W-1:0] level_q;
  logic [LVL_W-1:0] level_d;
  logic [CNT_W-1:0] cnt_q;
  logic             out_wenable_q;
  logic             out_rs_q;
  logic [7:0]       out_wdata_q;
  logic             drop_q;
  logic             in_ready;
  logic             push;
  logic             pop;
  logic             is_long;

  // Handshake decode: readiness depends only on the registered level, so a
  // pop in the same cycle can never rescue a write offered to a full FIFO.
  always_comb begin
    in_ready = (level_q != LVL_W'(DEPTH));
    push     = bus.in_valid && in_ready;
    pop      = (state_q == IDLE) && (level_q != '0);
    is_long  = !out_rs_q && (out_wdata_q >= 8'h01) && (out_wdata_q <= 8'h03);
    level_d  = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  // FIFO storage; contents need no reset since level gates every read.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      mem_q[wr_ptr_q] <= {bus.in_rs, bus.in_data};
    end
  end

  // FIFO pointers, occupancy and the refused-write pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      drop_q   <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      level_q <= level_d;
      drop_q  <= bus.in_valid && !in_ready;
    end
  end

  // Issue sequencer: pop into the output registers, strobe once, then wait.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      out_wenable_q <= 1'b0;
      out_rs_q      <= 1'b0;
      out_wdata_q   <= 8'h00;
    end else begin
      out_wenable_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (pop) begin
            {out_rs_q, out_wdata_q} <= mem_q[rd_ptr_q];
            out_wenable_q           <= 1'b1;
            state_q                 <= ISSUE;
          end
        end
        ISSUE: begin
          cnt_q   <= is_long ? CNT_W'(LONG_WAIT - 1) : CNT_W'(SHORT_WAIT - 1);
          state_q <= WAIT;
        end
        WAIT: begin
          if (cnt_q == '0) begin
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.in_ready    = in_ready;
  assign bus.out_wenable = out_wenable_q;
  assign bus.out_rs      = out_rs_q;
  assign bus.out_wdata   = out_wdata_q;
  assign bus.busy        = (level_q != '0) || (state_q != IDLE);
  assign bus.level       = level_q;
  assign bus.drop        = drop_q;
endmodule

// File: tb/tb_lcd_cmd_pacer.sv
// Bench for lcd_cmd_pacer with DEPTH=4, SHORT_WAIT=4, LONG_WAIT=10.
// Cycle labels are the value of cyc seen at a falling edge; a push driven at
// label p is sampled by the next rising edge and its strobe appears at p+2.
module tb_lcd_cmd_pacer;
  localparam int DEPTH = 4;

  typedef struct {
    logic       rs;
    logic [7:0] data;
    int         cyc;
  } ev_t;

  logic clk;
  logic rst;
  int   cyc;
  int   checks;
  int   failures;
  ev_t  sb_q [$];
  ev_t  obs_q [$];
  ev_t  mon_e;

  lcd_cmd_pacer_if #(.DEPTH(DEPTH)) bus ();

  lcd_cmd_pacer #(
    .DEPTH(DEPTH), .SHORT_WAIT(4), .LONG_WAIT(10), .CNT_W(17)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Record every strobe with its cycle label; tests compare against sb_q.
  always @(negedge clk) begin
    if (bus.out_wenable === 1'b1) begin
      mon_e.rs   = bus.out_rs;
      mon_e.data = bus.out_wdata;
      mon_e.cyc  = cyc;
      obs_q.push_back(mon_e);
      $display("strobe cyc=%0d rs=%0b data=%02h", cyc, bus.out_rs, bus.out_wdata);
    end
  end

  task automatic drive(input logic v, input logic rs, input logic [7:0] d);
    bus.in_valid = v;
    bus.in_rs    = rs;
    bus.in_data  = d;
    @(negedge clk);
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic expect_cmd(input logic rs, input logic [7:0] d, input int c);
    ev_t e;
    e.rs = rs; e.data = d; e.cyc = c;
    sb_q.push_back(e);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b0, 1'b0, 8'h00);
    drive(1'b1, 1'b1, 8'h77);
    rst = 1'b0;
    drive(1'b0, 1'b0, 8'h00);
    checks += 6;
    if (bus.out_wenable !== 1'b0) begin failures++; $display("FAIL reset_wenable got=%b want=0", bus.out_wenable); end
    if (bus.out_wdata !== 8'h00) begin failures++; $display("FAIL reset_wdata got=%02h want=00", bus.out_wdata); end
    if (bus.level !== 3'd0) begin failures++; $display("FAIL reset_level got=%0d want=0", bus.level); end
    if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b want=1", bus.in_ready); end
    if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", bus.busy); end
    if (bus.drop !== 1'b0) begin failures++; $display("FAIL reset_drop got=%b want=0", bus.drop); end
    wait_until(cyc + 5);
    checks++;
    if (obs_q.size() != 0) begin failures++; $display("FAIL reset_push_ignored got=%0d strobes want=0", obs_q.size()); end
    obs_q.delete();
  endtask

  task automatic test_single();
    int p;
    ev_t e, o;
    p = cyc;
    expect_cmd(1'b1, 8'h41, p + 2);
    drive(1'b1, 1'b1, 8'h41);
    drive(1'b0, 1'b0, 8'h00);
    wait_until(p + 6);
    checks++;
    if (bus.busy !== 1'b1) begin failures++; $display("FAIL single_busy_hi got=%b want=1", bus.busy); end
    wait_until(p + 7);
    checks++;
    if (bus.busy !== 1'b0) begin failures++; $display("FAIL single_busy_lo got=%b want=0", bus.busy); end
    wait_until(p + 20);
    checks++;
    if (obs_q.size() != sb_q.size()) begin failures++; $display("FAIL single_count got=%0d want=%0d", obs_q.size(), sb_q.size()); end
    while (sb_q.size() > 0 && obs_q.size() > 0) begin
      e = sb_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o.rs !== e.rs || o.data !== e.data || o.cyc !== e.cyc) begin
        failures++;
        $display("FAIL single_strobe got rs=%0b data=%02h cyc=%0d want rs=%0b data=%02h cyc=%0d", o.rs, o.data, o.cyc - p, e.rs, e.data, e.cyc - p);
      end
    end
    sb_q.delete(); obs_q.delete();
  endtask

  task automatic test_back_to_back();
    int p;
    ev_t e, o;
    p = cyc;
    for (int k = 0; k < 3; k++) begin
      expect_cmd(1'b1, 8'(8'h41 + k), p + 2 + 6 * k);
      drive(1'b1, 1'b1, 8'(8'h41 + k));
    end
    drive(1'b0, 1'b0, 8'h00);
    wait_until(p + 25);
    checks++;
    if (obs_q.size() != sb_q.size()) begin failures++; $display("FAIL b2b_count got=%0d want=%0d", obs_q.size(), sb_q.size()); end
    while (sb_q.size() > 0 && obs_q.size() > 0) begin
      e = sb_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o.rs !== e.rs || o.data !== e.data || o.cyc !== e.cyc) begin
        failures++;
        $display("FAIL b2b_strobe got rs=%0b data=%02h cyc=%0d want rs=%0b data=%02h cyc=%0d", o.rs, o.data, o.cyc - p, e.rs, e.data, e.cyc - p);
      end
    end
    sb_q.delete(); obs_q.delete();
  endtask

  task automatic test_long_wait();
    int p, q;
    ev_t e, o;
    p = cyc;
    expect_cmd(1'b0, 8'h01, p + 2);
    expect_cmd(1'b1, 8'h41, p + 14);
    drive(1'b1, 1'b0, 8'h01);
    drive(1'b1, 1'b1, 8'h41);
    drive(1'b0, 1'b0, 8'h00);
    wait_until(p + 30);
    // Range edges: instruction 0x04 is short, 0x03 is long, data 0x01 is short.
    q = cyc;
    expect_cmd(1'b0, 8'h04, q + 2);
    expect_cmd(1'b0, 8'h03, q + 8);
    expect_cmd(1'b1, 8'h01, q + 20);
    drive(1'b1, 1'b0, 8'h04);
    drive(1'b1, 1'b0, 8'h03);
    drive(1'b1, 1'b1, 8'h01);
    drive(1'b0, 1'b0, 8'h00);
    wait_until(q + 30);
    checks++;
    if (obs_q.size() != sb_q.size()) begin failures++; $display("FAIL long_count got=%0d want=%0d", obs_q.size(), sb_q.size()); end
    while (sb_q.size() > 0 && obs_q.size() > 0) begin
      e = sb_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o.rs !== e.rs || o.data !== e.data || o.cyc !== e.cyc) begin
        failures++;
        $display("FAIL long_strobe got rs=%0b data=%02h cyc=%0d want rs=%0b data=%02h cyc=%0d", o.rs, o.data, o.cyc - p, e.rs, e.data, e.cyc - p);
      end
    end
    sb_q.delete(); obs_q.delete();
  endtask

  task automatic test_overflow();
    int p;
    ev_t e, o;
    p = cyc;
    for (int k = 0; k < 6; k++) begin
      if (k == 5) begin
        checks += 3;
        if (bus.level !== 3'd4) begin failures++; $display("FAIL ovf_level got=%0d want=4", bus.level); end
        if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL ovf_ready got=%b want=0", bus.in_ready); end
        if (bus.drop !== 1'b0) begin failures++; $display("FAIL ovf_drop_early got=%b want=0", bus.drop); end
      end else begin
        expect_cmd(1'b1, 8'(8'h50 + k), p + 2 + 6 * k);
      end
      drive(1'b1, 1'b1, 8'(8'h50 + k));
    end
    checks++;
    if (bus.drop !== 1'b1) begin failures++; $display("FAIL ovf_drop got=%b want=1", bus.drop); end
    drive(1'b0, 1'b0, 8'h00);
    checks++;
    if (bus.drop !== 1'b0) begin failures++; $display("FAIL ovf_drop_late got=%b want=0", bus.drop); end
    wait_until(p + 40);
    checks++;
    if (obs_q.size() != sb_q.size()) begin failures++; $display("FAIL ovf_count got=%0d want=%0d", obs_q.size(), sb_q.size()); end
    while (sb_q.size() > 0 && obs_q.size() > 0) begin
      e = sb_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o.rs !== e.rs || o.data !== e.data || o.cyc !== e.cyc) begin
        failures++;
        $display("FAIL ovf_strobe got rs=%0b data=%02h cyc=%0d want rs=%0b data=%02h cyc=%0d", o.rs, o.data, o.cyc - p, e.rs, e.data, e.cyc - p);
      end
    end
    sb_q.delete(); obs_q.delete();
  endtask

  task automatic test_reset_mid_wait();
    int p;
    ev_t e, o;
    p = cyc;
    expect_cmd(1'b1, 8'h61, p + 2);
    for (int k = 0; k < 3; k++) drive(1'b1, 1'b1, 8'(8'h61 + k));
    drive(1'b0, 1'b0, 8'h00);
    // Label p+4 is inside the first WAIT; a push offered with reset must vanish.
    rst = 1'b1;
    drive(1'b1, 1'b0, 8'h99);
    rst = 1'b0;
    checks += 3;
    if (bus.level !== 3'd0) begin failures++; $display("FAIL rstwait_level got=%0d want=0", bus.level); end
    if (bus.busy !== 1'b0) begin failures++; $display("FAIL rstwait_busy got=%b want=0", bus.busy); end
    if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL rstwait_ready got=%b want=1", bus.in_ready); end
    drive(1'b0, 1'b0, 8'h00);
    wait_until(p + 30);
    checks++;
    if (obs_q.size() != sb_q.size()) begin failures++; $display("FAIL rstwait_count got=%0d want=%0d", obs_q.size(), sb_q.size()); end
    while (sb_q.size() > 0 && obs_q.size() > 0) begin
      e = sb_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o.rs !== e.rs || o.data !== e.data || o.cyc !== e.cyc) begin
        failures++;
        $display("FAIL rstwait_strobe got rs=%0b data=%02h cyc=%0d want rs=%0b data=%02h cyc=%0d", o.rs, o.data, o.cyc - p, e.rs, e.data, e.cyc - p);
      end
    end
    sb_q.delete(); obs_q.delete();
  endtask

  initial begin
    checks       = 0;
    failures     = 0;
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_rs    = 1'b0;
    bus.in_data  = 8'h00;
    @(negedge clk);
    test_reset();
    test_single();
    test_back_to_back();
    test_long_wait();
    test_overflow();
    test_reset_mid_wait();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end
endmodule
